// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RV32I-subset controller.
package mc_pkg;

    localparam int unsigned OP_W  = 7;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned ALU_W = 3;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_TRAP
    } state_t;

    localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

    localparam logic [F3_W-1:0] F3_WORD = 3'b010;
    localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b101;
    localparam logic [ALU_W-1:0] ALU_SLL = 3'b110;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RD1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RD2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] IMM_I = 2'b00;
    localparam logic [SEL_W-1:0] IMM_S = 2'b01;
    localparam logic [SEL_W-1:0] IMM_B = 2'b10;
    localparam logic [SEL_W-1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_aludec.sv
// ALU control decoder: maps ALUOp and funct fields to an ALU operation plus legality.
module mc_aludec
    import mc_pkg::*;
(
    input  logic             op5,
    input  logic [F3_W-1:0]  funct3,
    input  logic             funct7b5,
    input  logic [SEL_W-1:0] alu_op,
    output logic [ALU_W-1:0] alu_control,
    output logic             legal
);

    logic [ALU_W-1:0] funct_ctrl;

    // Decode funct fields (legality is independent of ALUOp) then select by ALUOp.
    always_comb begin
        funct_ctrl  = ALU_ADD;
        legal       = 1'b1;
        alu_control = ALU_ADD;
        case (funct3)
            3'b000: funct_ctrl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001: begin
                funct_ctrl = ALU_SLL;
                legal      = !funct7b5;
            end
            3'b010: funct_ctrl = ALU_SLT;
            3'b110: funct_ctrl = ALU_OR;
            3'b111: funct_ctrl = ALU_AND;
            default: legal = 1'b0;
        endcase
        case (alu_op)
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: alu_control = funct_ctrl;
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multicycle RV32I-subset datapath.
module multicycle_controller
    import mc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  op,
    input  logic [F3_W-1:0]  funct3,
    input  logic             funct7b5,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [SEL_W-1:0] ResultSrc,
    output logic [SEL_W-1:0] ALUSrcA,
    output logic [SEL_W-1:0] ALUSrcB,
    output logic [SEL_W-1:0] ImmSrc,
    output logic [ALU_W-1:0] ALUControl,
    output logic             RegWrite,
    output logic             instr_done,
    output logic             illegal
);

    state_t           state;
    state_t           state_n;
    logic [SEL_W-1:0] alu_op;
    logic             funct_legal;

    // ALUOp depends only on state, keeping the decoder outside the FSM's comb loop.
    assign alu_op = (state == S_EXECUTER || state == S_EXECUTEI) ? ALUOP_FUNCT :
                    (state == S_BEQ)                              ? ALUOP_SUB   :
                                                                    ALUOP_ADD;

    mc_aludec u_aludec (
        .op5         (op[5]),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_op      (alu_op),
        .alu_control (ALUControl),
        .legal       (funct_legal)
    );

    // State register; reset forces FETCH immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and Moore outputs; only FETCH/MEMWRITE/BEQ look at inputs.
    always_comb begin
        state_n    = state;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        ImmSrc     = IMM_I;
        RegWrite   = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                // gated so a held-low reset never lets a fetch strobe through
                IRWrite   = mem_ready & reset;
                PCWrite   = mem_ready & reset;
                if (mem_ready) state_n = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_B;
                case (op)
                    OP_LW, OP_SW: state_n = (funct3 == F3_WORD) ? S_MEMADR : S_TRAP;
                    OP_R:         state_n = funct_legal ? S_EXECUTER : S_TRAP;
                    OP_I:         state_n = funct_legal ? S_EXECUTEI : S_TRAP;
                    OP_BEQ:       state_n = (funct3 == F3_BEQ) ? S_BEQ : S_TRAP;
                    OP_JAL:       state_n = S_JAL;
                    default:      state_n = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = op[5] ? IMM_S : IMM_I;
                state_n = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_n = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_n    = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) state_n = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
                state_n = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_I;
                state_n = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_n    = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_RD2;
                PCWrite    = Zero;
                instr_done = 1'b1;
                state_n    = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
                state_n = S_ALUWB;
            end
            S_TRAP: begin
                illegal = 1'b1;
                state_n = S_TRAP;
            end
            default: state_n = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller against an instruction-recipe model.
module tb_multicycle_controller;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3, P_MEMWB = 4,
                   P_MEMWRITE = 5, P_EXR = 6, P_EXI = 7, P_ALUWB = 8, P_BEQ = 9,
                   P_JAL = 10, P_TRAP = 11;

    localparam int M_LW = 0, M_SW = 1, M_ADD = 2, M_SUB = 3, M_AND = 4, M_OR = 5,
                   M_SLT = 6, M_SLL = 7, M_ADDI = 8, M_ANDI = 9, M_ORI = 10,
                   M_SLTI = 11, M_SLLI = 12, M_BEQ = 13, M_JAL = 14, M_ILL = 15;

    typedef struct {
        int         mn;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
    } instr_t;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [17:0] dut_vec;

    int     errors = 0;
    int     checks = 0;
    int     cur = P_FETCH;
    int     steps[$];
    instr_t pending[$];
    instr_t cur_instr;
    int     cyc_count;
    int     done_at[$];
    int     n_pcw, n_irw, n_mw, n_adr, n_rw, n_ill, n_done_total;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .RegWrite   (RegWrite),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    assign dut_vec = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                      ImmSrc, ALUControl, RegWrite, instr_done, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] imm, input logic [2:0] alu,
                                       input logic rw, input logic done, input logic ill);
        return {pcw, adr, mw, irw, rs, sa, sb, imm, alu, rw, done, ill};
    endfunction

    // Outputs while reset is held: fetch selects, every strobe quiet.
    function automatic logic [17:0] reset_exp();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
    endfunction

    // ALU operation each mnemonic asks for in its execute step.
    function automatic logic [2:0] alu_code(input int mn);
        case (mn)
            M_SUB:          return 3'b001;
            M_AND, M_ANDI:  return 3'b010;
            M_OR, M_ORI:    return 3'b011;
            M_SLT, M_SLTI:  return 3'b101;
            M_SLL, M_SLLI:  return 3'b110;
            default:        return 3'b000;
        endcase
    endfunction

    // What the datapath controls must be during one step of an instruction.
    function automatic logic [17:0] expect_out(input int step, input int mn,
                                               input logic mr, input logic z);
        case (step)
            P_FETCH:    return mk(mr, 1'b0, 1'b0, mr, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
            P_DECODE:   return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0);
            P_MEMADR:   return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01,
                                  (mn == M_SW) ? 2'b01 : 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
            P_MEMREAD:  return mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
            P_MEMWB:    return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1, 1'b0);
            P_MEMWRITE: return mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, mr, 1'b0);
            P_EXR:      return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, alu_code(mn), 1'b0, 1'b0, 1'b0);
            P_EXI:      return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, alu_code(mn), 1'b0, 1'b0, 1'b0);
            P_ALUWB:    return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1, 1'b0);
            P_BEQ:      return mk(z, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 1'b0, 1'b1, 1'b0);
            P_JAL:      return mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
            default:    return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1);
        endcase
    endfunction

    function automatic instr_t mk_instr(input int mn, input logic [6:0] o,
                                        input logic [2:0] f3, input logic f7);
        instr_t r;
        r.mn = mn; r.op = o; r.f3 = f3; r.f7 = f7;
        return r;
    endfunction

    function automatic bit legal_op(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
    endfunction

    // Random instruction from its mnemonic; don't-care fields are randomized too.
    function automatic instr_t rand_instr();
        instr_t r;
        int m;
        int v;
        m = $urandom_range(0, 19);
        if (m > 15) m = $urandom_range(0, 14);
        r.mn = m;
        r.f7 = 1'($urandom_range(0, 1));
        r.f3 = 3'($urandom_range(0, 7));
        case (m)
            M_LW:   begin r.op = 7'b0000011; r.f3 = 3'b010; end
            M_SW:   begin r.op = 7'b0100011; r.f3 = 3'b010; end
            M_ADD:  begin r.op = 7'b0110011; r.f3 = 3'b000; r.f7 = 1'b0; end
            M_SUB:  begin r.op = 7'b0110011; r.f3 = 3'b000; r.f7 = 1'b1; end
            M_AND:  begin r.op = 7'b0110011; r.f3 = 3'b111; r.f7 = 1'b0; end
            M_OR:   begin r.op = 7'b0110011; r.f3 = 3'b110; r.f7 = 1'b0; end
            M_SLT:  begin r.op = 7'b0110011; r.f3 = 3'b010; r.f7 = 1'b0; end
            M_SLL:  begin r.op = 7'b0110011; r.f3 = 3'b001; r.f7 = 1'b0; end
            M_ADDI: begin r.op = 7'b0010011; r.f3 = 3'b000; end
            M_ANDI: begin r.op = 7'b0010011; r.f3 = 3'b111; end
            M_ORI:  begin r.op = 7'b0010011; r.f3 = 3'b110; end
            M_SLTI: begin r.op = 7'b0010011; r.f3 = 3'b010; end
            M_SLLI: begin r.op = 7'b0010011; r.f3 = 3'b001; r.f7 = 1'b0; end
            M_BEQ:  begin r.op = 7'b1100011; r.f3 = 3'b000; end
            M_JAL:  r.op = 7'b1101111;
            default: begin
                v = $urandom_range(0, 4);
                case (v)
                    0: begin
                        r.op = 7'($urandom);
                        while (legal_op(r.op)) r.op = 7'($urandom);
                    end
                    1: begin
                        r.op = ($urandom_range(0, 1) != 0) ? 7'b0110011 : 7'b0010011;
                        r.f3 = 3'(3 + $urandom_range(0, 2));
                    end
                    2: begin
                        r.op = ($urandom_range(0, 1) != 0) ? 7'b0110011 : 7'b0010011;
                        r.f3 = 3'b001;
                        r.f7 = 1'b1;
                    end
                    3: begin
                        r.op = ($urandom_range(0, 1) != 0) ? 7'b0000011 : 7'b0100011;
                        while (r.f3 == 3'b010) r.f3 = 3'($urandom_range(0, 7));
                    end
                    default: begin
                        r.op = 7'b1100011;
                        while (r.f3 == 3'b000) r.f3 = 3'($urandom_range(0, 7));
                    end
                endcase
            end
        endcase
        return r;
    endfunction

    // Steps an instruction walks through after its fetch.
    task automatic load_recipe(input int mn);
        steps.delete();
        steps.push_back(P_DECODE);
        case (mn)
            M_LW:  begin steps.push_back(P_MEMADR); steps.push_back(P_MEMREAD); steps.push_back(P_MEMWB); end
            M_SW:  begin steps.push_back(P_MEMADR); steps.push_back(P_MEMWRITE); end
            M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_SLL:
                   begin steps.push_back(P_EXR); steps.push_back(P_ALUWB); end
            M_ADDI, M_ANDI, M_ORI, M_SLTI, M_SLLI:
                   begin steps.push_back(P_EXI); steps.push_back(P_ALUWB); end
            M_BEQ: steps.push_back(P_BEQ);
            M_JAL: begin steps.push_back(P_JAL); steps.push_back(P_ALUWB); end
            default: steps.push_back(P_TRAP);
        endcase
    endtask

    task automatic check_vec(input string name, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t step=%0d mn=%0d got=%b expected=%b", name, $time, cur, cur_instr.mn, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int done_cycle(input int i);
        return (done_at.size() > i) ? done_at[i] : -1;
    endfunction

    task automatic clr();
        cyc_count = 0; done_at.delete();
        n_pcw = 0; n_irw = 0; n_mw = 0; n_adr = 0; n_rw = 0; n_ill = 0;
    endtask

    // Model moves on once the step has finished (memory steps wait on mem_ready).
    task automatic advance(input logic mr);
        if (cur == P_TRAP) return;
        if ((cur == P_FETCH || cur == P_MEMREAD || cur == P_MEMWRITE) && !mr) return;
        if (cur == P_FETCH) begin
            if (pending.size() > 0) cur_instr = pending.pop_front();
            else                    cur_instr = rand_instr();
            op = cur_instr.op; funct3 = cur_instr.f3; funct7b5 = cur_instr.f7;
            load_recipe(cur_instr.mn);
        end
        if (steps.size() == 0) cur = P_FETCH;
        else                   cur = steps.pop_front();
    endtask

    // One clock: drive at negedge, compare mid-low-phase, advance model after posedge.
    task automatic cycle(input logic mr, input logic z);
        logic [17:0] e;
        @(negedge clk);
        mem_ready = mr;
        Zero      = z;
        #1;
        cyc_count++;
        e = expect_out(cur, cur_instr.mn, mr, z);
        check_vec("outputs", dut_vec, e);
        if (PCWrite)    n_pcw++;
        if (IRWrite)    n_irw++;
        if (MemWrite)   n_mw++;
        if (AdrSrc)     n_adr++;
        if (RegWrite)   n_rw++;
        if (illegal)    n_ill++;
        if (instr_done) begin done_at.push_back(cyc_count); n_done_total++; end
        @(posedge clk);
        #1;
        advance(mr);
    endtask

    task automatic reset_seq();
        @(negedge clk);
        mem_ready = 1'($urandom_range(0, 1));
        #2 reset = 1'b0;
        #1 check_vec("reset_outputs", dut_vec, reset_exp());
        cur = P_FETCH;
        steps.delete();
        @(posedge clk);
        #1 check_vec("reset_held", dut_vec, reset_exp());
        #1 reset = 1'b1;
    endtask

    initial begin
        int p_lw[10] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
        int p_sw[6]  = '{1, 1, 1, 0, 0, 1};
        int trap_cycles;
        reset = 1'b0; mem_ready = 1'b1; Zero = 1'b0;
        op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
        cur_instr = mk_instr(M_ILL, 7'd0, 3'd0, 1'b0);
        n_done_total = 0;
        clr();
        #2 check_vec("reset_initial", dut_vec, reset_exp());
        #4 check_vec("reset_after_edge", dut_vec, reset_exp());
        #1 reset = 1'b1;

        // addi then add, no stalls
        pending.push_back(mk_instr(M_ADDI, 7'b0010011, 3'b000, 1'b0));
        pending.push_back(mk_instr(M_ADD,  7'b0110011, 3'b000, 1'b0));
        clr();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);
        check_int("addi_done_cycle", done_cycle(0), 4);
        check_int("add_done_cycle", done_cycle(1), 8);
        check_int("alu_regwrite_count", n_rw, 2);

        // lw with 2 fetch stalls and 3 read stalls
        pending.push_back(mk_instr(M_LW, 7'b0000011, 3'b010, 1'b0));
        clr();
        for (int i = 0; i < 10; i++) cycle(1'(p_lw[i]), 1'b0);
        check_int("lw_done_cycle", done_cycle(0), 10);
        check_int("lw_irwrite_count", n_irw, 1);
        check_int("lw_pcwrite_count", n_pcw, 1);

        // sw with 2 write stalls
        pending.push_back(mk_instr(M_SW, 7'b0100011, 3'b010, 1'b0));
        clr();
        for (int i = 0; i < 6; i++) cycle(1'(p_sw[i]), 1'b0);
        check_int("sw_memwrite_cycles", n_mw, 3);
        check_int("sw_adrsrc_cycles", n_adr, 3);
        check_int("sw_pcwrite_fetch_only", n_pcw, 1);
        check_int("sw_done_cycle", done_cycle(0), 6);

        // beq taken then not taken
        pending.push_back(mk_instr(M_BEQ, 7'b1100011, 3'b000, 1'b0));
        clr();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
        check_int("beq_taken_pcwrite", n_pcw, 2);
        check_int("beq_taken_done", done_cycle(0), 3);
        pending.push_back(mk_instr(M_BEQ, 7'b1100011, 3'b000, 1'b1));
        clr();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
        check_int("beq_fall_pcwrite", n_pcw, 1);
        check_int("beq_fall_done", done_cycle(0), 3);

        // jal
        pending.push_back(mk_instr(M_JAL, 7'b1101111, 3'b011, 1'b1));
        clr();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
        check_int("jal_done_count", done_at.size(), 1);
        check_int("jal_done_cycle", done_cycle(0), 4);
        check_int("jal_pcwrite_count", n_pcw, 2);
        check_int("jal_regwrite_count", n_rw, 1);

        // illegal encodings: system op, R funct3=101, lw funct3=000
        for (int k = 0; k < 3; k++) begin
            if (k == 0)      pending.push_back(mk_instr(M_ILL, 7'b1110011, 3'b000, 1'b0));
            else if (k == 1) pending.push_back(mk_instr(M_ILL, 7'b0110011, 3'b101, 1'b0));
            else             pending.push_back(mk_instr(M_ILL, 7'b0000011, 3'b000, 1'b0));
            clr();
            for (int i = 0; i < 5; i++) cycle(1'b1, 1'($urandom_range(0, 1)));
            check_int("trap_illegal_cycles", n_ill, 3);
            check_int("trap_pcwrite_count", n_pcw, 1);
            check_int("trap_other_writes", n_rw + n_mw + done_at.size(), 0);
            reset_seq();
        end

        // reset during a stalled store
        pending.push_back(mk_instr(M_SW, 7'b0100011, 3'b010, 1'b0));
        clr();
        cycle(1'b1, 1'b0); cycle(1'b1, 1'b0); cycle(1'b1, 1'b0); cycle(1'b0, 1'b0);
        @(negedge clk);
        mem_ready = 1'b0;
        #1 check_int("sw_stall_memwrite", int'(MemWrite), 1);
        #2 reset = 1'b0;
        #1 check_int("memwrite_async_drop", int'(MemWrite), 0);
        cur = P_FETCH;
        steps.delete();
        @(posedge clk);
        #1 check_vec("reset_in_store", dut_vec, reset_exp());
        #1 reset = 1'b1;
        pending.push_back(mk_instr(M_ADDI, 7'b0010011, 3'b000, 1'b1));
        clr();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
        check_int("restart_done_cycle", done_cycle(0), 4);
        check_int("restart_no_memwrite", n_mw, 0);

        // random traffic with random stalls, branches and resets
        trap_cycles = 0;
        n_done_total = 0;
        for (int i = 0; i < 4000; i++) begin
            if (cur == P_TRAP) trap_cycles++;
            if (trap_cycles >= 3 || $urandom_range(0, 299) == 0) begin
                reset_seq();
                trap_cycles = 0;
            end else begin
                cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)));
            end
        end
        checks++;
        if (n_done_total < 100) begin
            errors++;
            $display("FAIL random_progress got=%0d expected at least 100 completions", n_done_total);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
